serial_addsub_unit: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor. It extends the fixed-width ripple subtractor with an add/subtract mode select, a configurable word width, and digit-serial processing of DIGIT bits per clock. A start/busy/done handshake and registered status flags (carry/borrow, signed overflow, zero) are added. It sits in the datapath wherever a narrow, area-cheap arithmetic unit is acceptable and a result every WIDTH/DIGIT+1 cycles meets throughput.

---
 rtl/serial_addsub_unit.sv | 166 ++++++++++++++++
 tb/tb_serial_addsub_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_unit
// Purpose  : Digit-serial two's-complement adder/subtractor. Processes DIGIT
//            bits per clock over N = WIDTH/DIGIT cycles, with a start/busy/
//            done handshake and registered carry/borrow, overflow and zero
//            status flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub_mode,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int c_NUM_DIGITS = WIDTH / DIGIT;
    localparam int c_CNT_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(c_NUM_DIGITS - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;      // carry in add mode, borrow in subtract mode
    logic               r_sub;
    logic               r_xMsb;
    logic               r_yMsb;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_carryOut;
    logic               r_overflow;
    logic               r_zero;

    logic               w_start;
    logic               w_lastDigit;
    logic [DIGIT-1:0]   w_yDigit;
    logic               w_cin;
    logic [DIGIT:0]     w_digitSum;
    logic               w_carryNext;
    logic [WIDTH-1:0]   w_resNext;
    logic               w_resMsb;
    logic               w_ovf;

    // A start is only honoured while idle; starts during RUN are dropped.
    assign w_start     = (r_state == c_IDLE) && start;
    assign w_lastDigit = (r_cnt == c_LAST_DIGIT);

    // Subtraction is X + ~Y + ~borrow; the carry out of that sum is ~borrow.
    assign w_yDigit    = r_sub ? ~r_y[DIGIT-1:0] : r_y[DIGIT-1:0];
    assign w_cin       = r_sub ? ~r_carry : r_carry;
    assign w_digitSum  = {1'b0, r_x[DIGIT-1:0]} + {1'b0, w_yDigit} + {{DIGIT{1'b0}}, w_cin};
    assign w_carryNext = r_sub ? ~w_digitSum[DIGIT] : w_digitSum[DIGIT];

    // New digit enters the result shift register from the MSB end.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_resNext = w_digitSum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_resNext = {w_digitSum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Signed overflow from operand sign bits captured at start, since the
    // operand registers have been shifted away by the final digit.
    assign w_resMsb = w_resNext[WIDTH-1];
    assign w_ovf    = r_sub ? ((r_xMsb != r_yMsb) && (w_resMsb != r_xMsb))
                            : ((r_xMsb == r_yMsb) && (w_resMsb != r_xMsb));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: IDLE -> RUN on accepted start, RUN -> IDLE after last digit.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_stateNext = c_RUN;
                end
            end
            c_RUN: begin
                if (w_lastDigit) begin
                    w_stateNext = c_IDLE;
                end
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    // Datapath: operand capture, digit-serial shifting and result/flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_xMsb     <= 1'b0;
            r_yMsb     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_x     <= op_x;
                r_y     <= op_y;
                r_sub   <= sub_mode;
                r_carry <= carry_in;
                r_xMsb  <= op_x[WIDTH-1];
                r_yMsb  <= op_y[WIDTH-1];
                r_cnt   <= '0;
                r_res   <= '0;
            end else if (r_state == c_RUN) begin
                r_x     <= r_x >> DIGIT;
                r_y     <= r_y >> DIGIT;
                r_res   <= w_resNext;
                r_carry <= w_carryNext;
                r_cnt   <= r_cnt + c_CNT_W'(1);
                if (w_lastDigit) begin
                    r_result   <= w_resNext;
                    r_carryOut <= w_carryNext;
                    r_overflow <= w_ovf;
                    r_zero     <= (w_resNext == '0);
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == c_RUN);
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carryOut;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_unit
// Purpose  : Self-checking bench for serial_addsub_unit across several
//            (WIDTH, DIGIT) configurations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_unit;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          issue;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        subMode = 1'b0;
    logic        carryIn = 1'b0;
    logic [15:0] opX = '0;
    logic [15:0] opY = '0;
    logic [4:0]  startV = '0;
    int          cfg = 0;
    int          cyc = 0;
    bit          finishReq = 1'b0;

    logic [4:0]  busyV, doneV, coV, ovV, zV;
    logic [7:0]  res0, res1, res2;
    logic [15:0] res3;
    logic [4:0]  res4;
    logic [15:0] aRes;

    rec_t q[$];
    rec_t held = '{16'h0, 1'b0, 1'b0, 1'b0, 0};
    int   nTests = 0;
    int   nFail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_unit #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(startV[0]), .sub_mode(subMode),
        .op_x(opX[7:0]), .op_y(opY[7:0]), .carry_in(carryIn),
        .busy(busyV[0]), .done(doneV[0]), .result(res0),
        .carry_out(coV[0]), .overflow(ovV[0]), .zero(zV[0]));
    serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(startV[1]), .sub_mode(subMode),
        .op_x(opX[7:0]), .op_y(opY[7:0]), .carry_in(carryIn),
        .busy(busyV[1]), .done(doneV[1]), .result(res1),
        .carry_out(coV[1]), .overflow(ovV[1]), .zero(zV[1]));
    serial_addsub_unit #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(startV[2]), .sub_mode(subMode),
        .op_x(opX[7:0]), .op_y(opY[7:0]), .carry_in(carryIn),
        .busy(busyV[2]), .done(doneV[2]), .result(res2),
        .carry_out(coV[2]), .overflow(ovV[2]), .zero(zV[2]));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(startV[3]), .sub_mode(subMode),
        .op_x(opX), .op_y(opY), .carry_in(carryIn),
        .busy(busyV[3]), .done(doneV[3]), .result(res3),
        .carry_out(coV[3]), .overflow(ovV[3]), .zero(zV[3]));
    serial_addsub_unit #(.WIDTH(5), .DIGIT(5)) u_dut4 (
        .clk(clk), .rst(rst), .start(startV[4]), .sub_mode(subMode),
        .op_x(opX[4:0]), .op_y(opY[4:0]), .carry_in(carryIn),
        .busy(busyV[4]), .done(doneV[4]), .result(res4),
        .carry_out(coV[4]), .overflow(ovV[4]), .zero(zV[4]));

    // Route the active configuration's result onto a common 16-bit view.
    always_comb begin
        aRes = '0;
        case (cfg)
            0: aRes = {8'h0, res0};
            1: aRes = {8'h0, res1};
            2: aRes = {8'h0, res2};
            3: aRes = res3;
            4: aRes = {11'h0, res4};
            default: aRes = '0;
        endcase
    end

    function automatic int widthOf(input int c);
        case (c)
            3: return 16;
            4: return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int nOf(input int c);
        case (c)
            0: return 4;
            1: return 8;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    // Reference arithmetic: plain integer add/subtract with range checks.
    function automatic rec_t model(input int w, input bit sub, input logic [15:0] x,
                                   input logic [15:0] y, input bit cin);
        rec_t r;
        int ux, uy, sx, sy, full, s, half;
        ux   = int'(x);
        uy   = int'(y);
        half = 1 << (w - 1);
        sx   = (ux >= half) ? ux - 2 * half : ux;
        sy   = (uy >= half) ? uy - 2 * half : uy;
        if (sub) begin
            full = ux - uy - int'(cin);
            s    = sx - sy - int'(cin);
            r.co = (ux < uy + int'(cin));
        end else begin
            full = ux + uy + int'(cin);
            s    = sx + sy + int'(cin);
            r.co = (full >= 2 * half);
        end
        r.res   = 16'(full & (2 * half - 1));
        r.ov    = (s > half - 1) || (s < -half);
        r.z     = (r.res == 16'h0);
        r.issue = 0;
        return r;
    endfunction

    function automatic rec_t mk(input logic [15:0] res, input bit co, input bit ov, input bit z);
        rec_t r;
        r.res = res; r.co = co; r.ov = ov; r.z = z; r.issue = 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cfg=%0d cyc=%0d actual=%h expected=%h", name, cfg, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the timing and arithmetic model.
    always @(negedge clk) begin
        int   n, age;
        bit   expDone, expBusy;
        rec_t r;
        if (finishReq) begin
            chk("queue_empty", 16'(q.size()), 16'h0);
            $display("[TB] %0d tests run, %0d failed", nTests, nFail);
            $finish;
        end
        n       = nOf(cfg);
        expDone = 1'b0;
        expBusy = 1'b0;
        if (q.size() > 0) begin
            age     = cyc - q[0].issue;
            expDone = (age == n + 1);
            expBusy = (age >= 1) && (age <= n);
        end
        chk("busy", {15'h0, busyV[cfg]}, {15'h0, expBusy});
        chk("done", {15'h0, doneV[cfg]}, {15'h0, expDone});
        if (expDone) begin
            r = q.pop_front();
            chk("result",    aRes,                r.res);
            chk("carry_out", {15'h0, coV[cfg]},   {15'h0, r.co});
            chk("overflow",  {15'h0, ovV[cfg]},   {15'h0, r.ov});
            chk("zero",      {15'h0, zV[cfg]},    {15'h0, r.z});
            held = r;
        end else begin
            chk("hold_result",    aRes,              held.res);
            chk("hold_carry_out", {15'h0, coV[cfg]}, {15'h0, held.co});
            chk("hold_overflow",  {15'h0, ovV[cfg]}, {15'h0, held.ov});
            chk("hold_zero",      {15'h0, zV[cfg]},  {15'h0, held.z});
        end
        if (rst) begin
            q.delete();
            held = '{16'h0, 1'b0, 1'b0, 1'b0, 0};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input bit sub, input logic [15:0] x, input logic [15:0] y,
                           input bit cin, input bit lit, input rec_t litRec);
        rec_t r;
        tick();
        subMode = sub;
        opX     = x;
        opY     = y;
        carryIn = cin;
        startV  = 5'(1 << cfg);
        r       = lit ? litRec : model(widthOf(cfg), sub, x, y, cin);
        r.issue = cyc;
        q.push_back(r);
    endtask

    // Busy period; optionally keeps start high with junk operands.
    task automatic busyCycles(input bit spur);
        repeat (nOf(cfg)) begin
            tick();
            if (spur) begin
                startV  = 5'(1 << cfg);
                opX     = 16'($urandom);
                opY     = 16'($urandom);
                subMode = 1'($urandom);
                carryIn = 1'($urandom);
            end else begin
                startV = '0;
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            tick();
            startV = '0;
        end
    endtask

    task automatic switchCfg(input int c);
        tick(); rst = 1'b1; startV = '0;
        tick(); cfg = c;
        tick(); rst = 1'b0;
    endtask

    task automatic randOp(input bit spur);
        logic [15:0] mask;
        mask = 16'((1 << widthOf(cfg)) - 1);
        startOp(1'($urandom), 16'($urandom) & mask, 16'($urandom) & mask,
                1'($urandom), 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0));
        busyCycles(spur);
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Directed vectors, WIDTH=8 DIGIT=2.
        startOp(1'b1, 16'h05, 16'h03, 1'b0, 1'b1, mk(16'h02, 1'b0, 1'b0, 1'b0)); busyCycles(1'b0);
        startOp(1'b1, 16'h03, 16'h05, 1'b0, 1'b1, mk(16'hFE, 1'b1, 1'b0, 1'b0)); busyCycles(1'b0);
        idle(3);
        startOp(1'b1, 16'h80, 16'h01, 1'b0, 1'b1, mk(16'h7F, 1'b0, 1'b1, 1'b0)); busyCycles(1'b0);
        startOp(1'b0, 16'hFF, 16'h01, 1'b0, 1'b1, mk(16'h00, 1'b1, 1'b0, 1'b1)); busyCycles(1'b1);
        startOp(1'b0, 16'h7F, 16'h00, 1'b1, 1'b1, mk(16'h80, 1'b0, 1'b1, 1'b0)); busyCycles(1'b0);
        startOp(1'b1, 16'h00, 16'h00, 1'b1, 1'b1, mk(16'hFF, 1'b1, 1'b0, 1'b0)); busyCycles(1'b0);
        startOp(1'b0, 16'h80, 16'h80, 1'b0, 1'b1, mk(16'h00, 1'b1, 1'b1, 1'b1)); busyCycles(1'b0);
        idle(4);

        // Start held high continuously: back-to-back results every N+1 cycles.
        for (int i = 0; i < 4; i++) randOp(1'b1);
        idle(3);

        // Reset in cycle 2 of a RUN aborts it without a done pulse.
        startOp(1'b0, 16'h12, 16'h34, 1'b0, 1'b1, mk(16'h46, 1'b0, 1'b0, 1'b0));
        tick(); startV = '0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        idle(3);
        // Reset wins over a simultaneous start while idle.
        tick(); rst = 1'b1; startV = 5'b00001;
        tick(); rst = 1'b0; startV = '0;
        idle(2);
        startOp(1'b1, 16'h10, 16'h01, 1'b1, 1'b1, mk(16'h0E, 1'b0, 1'b0, 1'b0)); busyCycles(1'b0);
        idle(3);

        // Random sweeps over other configurations.
        for (int c = 1; c <= 4; c++) begin
            switchCfg(c);
            idle(1);
            for (int i = 0; i < 1000; i++) begin
                randOp(($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
            idle(3);
        end

        idle(2);
        tick();
        finishReq = 1'b1;
    end

endmodule
`default_nettype wire
